// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time helpers for the iterative CORDIC engine.
// Holds the FSM state enum, the arctangent table generator and the gain constants.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // CORDIC gain K ~= 1.64676 in Q2.14, and 1/K in Q1.15 for the downstream compensator.
  localparam int CORDIC_K     = 26981;
  localparam int CORDIC_K_INV = 19898;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // atan(2^-i) in binary angle units where 2^(zw-1) represents pi, rounded to nearest.
  function automatic int atan_lsb(input int i, input int zw);
    real a;
    a = $atan(2.0 ** (-i)) * (2.0 ** (zw - 1)) / 3.14159265358979;
    return $rtoi(a + 0.5);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation: combinational shift-add update of x, y and z.
// dir_pos=1 rotates counter-clockwise (dir=+1), dir_pos=0 clockwise.
module cordic_stage #(
  parameter int XW = 18,
  parameter int ZW = 16,
  parameter int SW = 4
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [SW-1:0] shift,
  input  logic signed [ZW-1:0] atan,
  input  logic                 dir_pos,
  output logic signed [XW-1:0] x_next,
  output logic signed [XW-1:0] y_next,
  output logic signed [ZW-1:0] z_next
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  always_comb begin
    if (dir_pos) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, early exit on zero residual.
// Define CORDIC_VECTOR_MODE_EN to add the in_mode port and vectoring support.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ZW    = 16,
  parameter int ITER  = 12,
  parameter int GW    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
`ifdef CORDIC_VECTOR_MODE_EN
  input  logic                          in_mode,
`endif
  output logic                          in_ready,
  input  logic signed [WIDTH-1:0]       in_x,
  input  logic signed [WIDTH-1:0]       in_y,
  input  logic signed [ZW-1:0]          in_z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WIDTH+GW-1:0]    out_x,
  output logic signed [WIDTH+GW-1:0]    out_y,
  output logic signed [ZW-1:0]          out_z,
  output logic [clog2(ITER+1)-1:0]      out_iters,
  output logic                          out_conv
);

  localparam int XW = WIDTH + GW;
  localparam int IW = clog2(ITER + 1);

  state_t               state;
  logic signed [XW-1:0] x_reg, y_reg;
  logic signed [ZW-1:0] z_reg;
  logic [IW-1:0]        iter_reg;
  logic                 conv_reg;
  logic                 vec_mode;

  logic signed [ZW-1:0] atan_tab [ITER];
  logic signed [XW-1:0] x_nx, y_nx;
  logic signed [ZW-1:0] z_nx;
  logic                 dir_pos;
  logic                 res_zero;
  logic                 res_zero_nx;
  logic                 last_iter;

  for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
    assign atan_tab[gi] = ZW'(atan_lsb(gi, ZW));
  end

`ifdef CORDIC_VECTOR_MODE_EN
  logic mode_reg;
  assign vec_mode = mode_reg;
`else
  assign vec_mode = 1'b0;
`endif

  // Rotation drives z to zero; vectoring drives y to zero.
  assign dir_pos     = vec_mode ? y_reg[XW-1] : ~z_reg[ZW-1];
  assign res_zero    = vec_mode ? (y_reg == '0) : (z_reg == '0);
  assign res_zero_nx = vec_mode ? (y_nx == '0) : (z_nx == '0);
  assign last_iter   = (iter_reg == IW'(ITER - 1));

  cordic_stage #(.XW(XW), .ZW(ZW), .SW(IW)) u_stage (
    .x       (x_reg),
    .y       (y_reg),
    .z       (z_reg),
    .shift   (iter_reg),
    .atan    (atan_tab[iter_reg]),
    .dir_pos (dir_pos),
    .x_next  (x_nx),
    .y_next  (y_nx),
    .z_next  (z_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      conv_reg  <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      iter_reg  <= '0;
`ifdef CORDIC_VECTOR_MODE_EN
      mode_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= XW'(in_x);
            y_reg    <= XW'(in_y);
            z_reg    <= in_z;
            iter_reg <= '0;
            conv_reg <= 1'b0;
            in_ready <= 1'b0;
`ifdef CORDIC_VECTOR_MODE_EN
            mode_reg <= in_mode;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          if (res_zero) begin
            conv_reg  <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            x_reg    <= x_nx;
            y_reg    <= y_nx;
            z_reg    <= z_nx;
            iter_reg <= iter_reg + IW'(1);
            if (last_iter) begin
              conv_reg  <= res_zero_nx;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_x     = x_reg;
  assign out_y     = y_reg;
  assign out_z     = z_reg;
  assign out_iters = iter_reg;
  assign out_conv  = conv_reg;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: random and directed operands checked against
// an integer CORDIC reference model; a separate monitor pops expectations on each handshake.
module tb_cordic_iter_engine;

  localparam int WIDTH = 16;
  localparam int ZW    = 16;
  localparam int ITER  = 12;
  localparam int GW    = 2;
  localparam int XW    = WIDTH + GW;
  localparam int IW    = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_mode = 1'b0;
  logic                     in_ready;
  logic signed [WIDTH-1:0]  in_x = '0;
  logic signed [WIDTH-1:0]  in_y = '0;
  logic signed [ZW-1:0]     in_z = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [XW-1:0]     out_x;
  logic signed [XW-1:0]     out_y;
  logic signed [ZW-1:0]     out_z;
  logic [IW-1:0]            out_iters;
  logic                     out_conv;

  cordic_iter_engine #(.WIDTH(WIDTH), .ZW(ZW), .ITER(ITER), .GW(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
`ifdef CORDIC_VECTOR_MODE_EN
    .in_mode   (in_mode),
`endif
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_iters (out_iters),
    .out_conv  (out_conv)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, z, iters, conv, lat, acc;
    int ax, ay, az, tol, tolz;
  } exp_t;

  exp_t exp_q[$];
  int   atan_tab[ITER];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_done = 0;
  bit   stall = 1'b0;
  bit   seen = 1'b0;
  int   meas_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_near(input string nm, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  // Textbook CORDIC on plain integers: drive the residual to zero, stop early when exact.
  function automatic exp_t model(input int x0, input int y0, input int z0, input bit vec);
    exp_t e;
    int x, y, z, nx, ny, nz, d, i;
    x = x0; y = y0; z = z0; i = 0;
    e = '{default: 0};
    while (1) begin
      if ((vec ? y : z) == 0) begin
        e.conv = 1;
        e.lat  = i + 1;
        break;
      end
      if (vec) d = (y < 0) ? 1 : -1;
      else     d = (z >= 0) ? 1 : -1;
      nx = x - d * (y >>> i);
      ny = y + d * (x >>> i);
      nz = z - d * atan_tab[i];
      x = nx; y = ny; z = nz;
      i++;
      if (i == ITER) begin
        e.conv = ((vec ? y : z) == 0) ? 1 : 0;
        e.lat  = ITER;
        break;
      end
    end
    e.x = x; e.y = y; e.z = z; e.iters = i;
    return e;
  endfunction

  task automatic send(input int x, input int y, input int z, input bit vec,
                      input int ax, input int ay, input int az, input int tol, input int tolz);
    exp_t e;
    int   n;
    e = model(x, y, z, vec);
    e.ax = ax; e.ay = ay; e.az = az; e.tol = tol; e.tolz = tolz;
    @(negedge clk);
    in_x = WIDTH'(x); in_y = WIDTH'(y); in_z = ZW'(z); in_mode = vec;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: decides backpressure each cycle and checks a result on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
      out_ready = 1'b0;
    end else begin
      out_ready = stall ? 1'b0 : ($urandom_range(3) != 0);
      if (out_valid && !seen) begin
        seen = 1'b1;
        meas_lat = cyc - ((exp_q.size() != 0) ? exp_q[0].acc : 0);
      end
      if (out_valid && out_ready) begin
        seen = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_x", int'(out_x), e.x);
          check("out_y", int'(out_y), e.y);
          check("out_z", int'(out_z), e.z);
          check("out_iters", int'(out_iters), e.iters);
          check("out_conv", int'(out_conv), e.conv);
          check("latency", meas_lat, e.lat);
          if (e.tol > 0 && e.iters == ITER) begin
            check_near("approx_x", int'(out_x), e.ax, e.tol);
            check_near("approx_y", int'(out_y), e.ay, e.tol);
            check_near("approx_z", int'(out_z), e.az, e.tolz);
          end
          n_done++;
          $display("op %0d: x=%0d y=%0d z=%0d iters=%0d conv=%0d", n_done,
                   int'(out_x), int'(out_y), int'(out_z), int'(out_iters), int'(out_conv));
        end
      end
    end
  end

  initial begin
    exp_t hold_e;
    int   rx, ry, rz;
    bit   rv;

    for (int i = 0; i < ITER; i++)
      atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * 32768.0 / 3.14159265358979 + 0.5);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_conv", int'(out_conv), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_iters", int'(out_iters), 0);
    rst_n = 1'b1;

    // Directed cases
    send(16384, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    send(10000, 0, 8192, 1'b0, 11645, 11645, 0, 24, 12);
    send(10000, 0, -16384, 1'b0, 0, -16468, 0, 24, 12);
    send(-20000, 12000, 16384, 1'b0, -19761, -32935, 0, 24, 12);
    send(32767, -32768, -16384, 1'b0, -53960, -53958, 0, 32, 12);
`ifdef CORDIC_VECTOR_MODE_EN
    send(3000, 4000, 0, 1'b1, 8234, 0, 9672, 24, 12);
`endif

    // Random operands with legal angles
    for (int k = 0; k < 40; k++) begin
      rx = $urandom_range(65535) - 32768;
      ry = $urandom_range(65535) - 32768;
      rz = ($urandom_range(3) == 0) ? atan_tab[$urandom_range(ITER - 1)]
                                    : $urandom_range(32768) - 16384;
      rv = 1'b0;
`ifdef CORDIC_VECTOR_MODE_EN
      rv = $urandom_range(1);
      if (rv) begin
        rx = $urandom_range(32767);
        rz = 0;
      end
`endif
      send(rx, ry, rz, rv, 0, 0, 0, 0, 0);
    end
    drain();

    // Backpressure: hold DONE and pulse in_valid; nothing new may be accepted
    stall = 1'b1;
    send(7000, -3000, 5000, 1'b0, 0, 0, 0, 0, 0);
    hold_e = exp_q[0];
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("bp_wait_valid", int'(out_valid), 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      in_x = 16'sd1234; in_y = 16'sd0; in_z = 16'sd100;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_x_stable", int'(out_x), hold_e.x);
      check("bp_out_y_stable", int'(out_y), hold_e.y);
    end
    @(negedge clk);
    in_valid = 1'b0;
    stall = 1'b0;
    drain();
    @(negedge clk);
    check("bp_idle_in_ready", int'(in_ready), 1);
    check("bp_no_ghost_valid", int'(out_valid), 0);

    // Reset mid-RUN at i=5 discards the operation
    send(10000, 0, 5000, 1'b0, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_run_iters", int'(out_iters), 5);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_out_valid", int'(out_valid), 0);
      check("post_rst_in_ready", int'(in_ready), 1);
    end
    send(10000, 0, 8192, 1'b0, 11645, 11645, 0, 24, 12);
    send(12000, 0, -9000, 1'b0, 0, 0, 0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
